// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, diff = a - b (mod 2^WIDTH).
// One bit per clock, LSB first, through two borrow-chained half-subtractor cells.
// diff/borrow are only updated when the last bit is processed, so they never
// expose partial results.
//
//   state | meaning
//   ------+----------------------------------------------------
//   IDLE  | waiting for start
//   SHIFT | one operand bit processed per clock (WIDTH clocks)
//   DONE  | one-cycle done pulse; start here begins a new op

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             bor_ff;
    logic [CNT_W-1:0] cnt;

    logic a0, b0, d1, br1, d, br2, bout;
    logic accept, last;
    logic [WIDTH-1:0] res_next;

    // Two half-subtractor cells chained through the borrow flop.
    always_comb begin
        a0       = a_sr[0];
        b0       = b_sr[0];
        d1       = a0 ^ b0;
        br1      = ~a0 & b0;
        d        = d1 ^ bor_ff;
        br2      = ~d1 & bor_ff;
        bout     = br1 | br2;
        res_next = {d, res_sr[WIDTH-1:1]};
        accept   = start && ((state == IDLE) || (state == DONE));
        last     = (state == SHIFT) && (cnt == CNT_LAST);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; start is only honoured in IDLE or DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (last)   state_nxt = DONE;
            DONE:    state_nxt = accept ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    // Operand/result shifting, borrow chain, bit counter and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            bor_ff <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            bor_ff <= 1'b0;
            cnt    <= '0;
        end else if (state == SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_next;
            bor_ff <= bout;
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
                diff   <= res_next;
                borrow <= bout;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8 directed/random, WIDTH=4 exhaustive).
`timescale 1ns/1ps
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, borrow8;
    logic [7:0] diff8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, borrow4;
    logic [3:0] diff4;

    int n_tests = 0;
    int n_fail  = 0;

    // last result the WIDTH=8 DUT should be holding ({borrow,diff})
    logic [8:0] held8 = '0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic.
    function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y);
        int dv;
        dv = int'(x) - int'(y);
        return {(x < y), 8'(dv & 8'hFF)};
    endfunction

    function automatic logic [4:0] ref4(input logic [3:0] x, input logic [3:0] y);
        int dv;
        dv = int'(x) - int'(y);
        return {(x < y), 4'(dv & 4'hF)};
    endfunction

    // One WIDTH=8 operation. Inputs driven and outputs sampled on negedges.
    // glitch_at>0 pulses start with a=glitch_a at that cycle of the operation.
    task automatic run8(input logic [7:0] x, input logic [7:0] y,
                        input int glitch_at, input logic [7:0] glitch_a);
        logic [8:0] exp;
        int busy_cnt;
        bit seen;
        exp = ref8(x, y);
        start8 = 1'b1; a8 = x; b8 = y;
        @(negedge clk);
        start8 = 1'b0; a8 = $urandom; b8 = $urandom;
        busy_cnt = 0;
        seen = 0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            if (n > 1) @(negedge clk);
            start8 = 1'b0;
            if (done8) begin
                seen = 1;
                check("done_cycle", n, 9);
                check("busy_in_done", busy8, 0);
                check("busy_cycles", busy_cnt, 8);
                check("result8", {borrow8, diff8}, exp);
            end else begin
                if (busy8) busy_cnt++;
                if (n == 2) check("held_during_op", {borrow8, diff8}, held8);
                if (glitch_at > 0 && n == glitch_at) begin
                    start8 = 1'b1; a8 = glitch_a;
                end
            end
        end
        if (!seen) check("done_timeout", 0, 1);
        held8 = exp;
        @(negedge clk);
        check("done_one_cycle", done8, 0);
    endtask

    task automatic run4(input logic [3:0] x, input logic [3:0] y);
        bit seen;
        start4 = 1'b1; a4 = x; b4 = y;
        @(negedge clk);
        start4 = 1'b0;
        seen = 0;
        for (int n = 0; n < 12 && !seen; n++) begin
            @(negedge clk);
            if (done4) begin
                seen = 1;
                check("exh4", {borrow4, diff4}, ref4(x, y));
            end
        end
        if (!seen) check("done4_timeout", 0, 1);
    endtask

    initial begin
        @(negedge clk);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_res", {borrow8, diff8}, 0);
        rst = 1'b0;
        @(negedge clk);

        run8(8'h05, 8'h03, 0, 8'h00);
        run8(8'h03, 8'h05, 0, 8'h00);
        run8(8'h00, 8'h01, 0, 8'h00);
        run8(8'hFF, 8'hFF, 0, 8'h00);
        run8(8'h00, 8'h00, 0, 8'h00);
        // start while busy must be ignored
        run8(8'h05, 8'h03, 3, 8'hAA);

        // reset mid-operation
        begin
            bit any_done;
            start8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
            @(negedge clk);
            start8 = 1'b0;
            repeat (3) @(negedge clk);
            rst = 1'b1;
            #1;
            check("midrst_busy", busy8, 0);
            check("midrst_done", done8, 0);
            check("midrst_res", {borrow8, diff8}, 0);
            @(negedge clk);
            rst = 1'b0;
            held8 = '0;
            any_done = 0;
            repeat (12) begin
                @(negedge clk);
                if (done8 || busy8) any_done = 1;
            end
            check("midrst_no_done", any_done, 0);
        end

        // back-to-back: start held high through DONE
        begin
            int first_n, second_n;
            logic [8:0] e1, e2;
            bit partial;
            e1 = ref8(8'h37, 8'h52);
            e2 = ref8(8'hC4, 8'h19);
            first_n = -1; second_n = -1; partial = 0;
            start8 = 1'b1; a8 = 8'h37; b8 = 8'h52;
            @(negedge clk);
            a8 = 8'hC4; b8 = 8'h19;
            for (int n = 1; n <= 30 && second_n < 0; n++) begin
                if (n > 1) @(negedge clk);
                if (done8) begin
                    if (first_n < 0) begin
                        first_n = n;
                        check("b2b_first", {borrow8, diff8}, e1);
                    end else begin
                        second_n = n;
                        check("b2b_second", {borrow8, diff8}, e2);
                    end
                end else if (first_n > 0) begin
                    start8 = 1'b0;
                    if ({borrow8, diff8} !== e1) partial = 1;
                end
            end
            start8 = 1'b0;
            check("b2b_first_cycle", first_n, 9);
            check("b2b_gap", second_n - first_n, 9);
            check("b2b_held", partial, 0);
            held8 = e2;
            @(negedge clk);
        end

        // random operands
        for (int k = 0; k < 40; k++) begin
            logic [7:0] x, y;
            x = 8'($urandom);
            y = (k % 5 == 0) ? x : 8'($urandom);
            run8(x, y, (k % 3 == 0) ? int'($urandom_range(2, 7)) : 0, 8'($urandom));
        end

        // WIDTH=4 exhaustive
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                run4(4'(x), 4'(y));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
